// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester simple_mem port arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 2;
  localparam int unsigned DW_DEF = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the requester not granted last wins ties.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_gnt_valid_c,
  output logic o_gnt_id_c
);

  always_comb begin
    o_gnt_valid_c = i_req0 | i_req1;
    o_gnt_id_c    = REQ0;
    if (i_req0 && i_req1) begin
      o_gnt_id_c = ~i_last_gnt;
    end else if (i_req1) begin
      o_gnt_id_c = REQ1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one simple_mem port between two requesters: round-robin grant,
// one-cycle write/read issue, read capture and a one-cycle ack per transaction.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_e    r_state, w_state_nxt;
  logic          r_last_gnt, w_last_gnt_nxt;
  logic          r_gnt_id, w_gnt_id_nxt;
  logic          r_we, w_we_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic          r_ack0, w_ack0_nxt;
  logic          r_ack1, w_ack1_nxt;
  logic          r_busy, w_busy_nxt;
  logic          w_gnt_valid;
  logic          w_gnt_id;

  rr_arb2 u_rr_arb2 (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last_gnt   (r_last_gnt),
    .o_gnt_valid_c(w_gnt_valid),
    .o_gnt_id_c   (w_gnt_id)
  );

  // State, latches and registered outputs; reset makes requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= REQ1;
      r_gnt_id   <= REQ0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_mem_we   <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Outputs are computed one state ahead so they are valid throughout the target state.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_gnt_nxt = r_last_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_mem_we_nxt   = 1'b0;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt    = ST_ISSUE;
          w_gnt_id_nxt   = w_gnt_id;
          w_last_gnt_nxt = w_gnt_id;
          if (w_gnt_id == REQ1) begin
            w_we_nxt    = we1;
            w_addr_nxt  = addr1;
            w_wdata_nxt = wdata1;
          end else begin
            w_we_nxt    = we0;
            w_addr_nxt  = addr0;
            w_wdata_nxt = wdata0;
          end
          w_mem_we_nxt = w_we_nxt;
        end
      end
      ST_ISSUE: begin
        if (r_we) begin
          w_state_nxt = ST_RESP;
          w_ack0_nxt  = (r_gnt_id == REQ0);
          w_ack1_nxt  = (r_gnt_id == REQ1);
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_rdata_nxt = mem_rdata;
        w_state_nxt = ST_RESP;
        w_ack0_nxt  = (r_gnt_id == REQ0);
        w_ack1_nxt  = (r_gnt_id == REQ1);
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata     = r_rdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized two-master traffic
// against a transaction-level model of grant order, latency and memory contents.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          req0   = 1'b0;
  logic          we0    = 1'b0;
  logic [AW-1:0] addr0  = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          req1   = 1'b0;
  logic          we1    = 1'b0;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          ack0, ack1, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  // Transaction-level model: grant edge s, ack offset lack, next IDLE sample idle_at.
  int            cyc     = 0;
  int            idle_at = -1;
  int            s       = 0;
  int            lack    = 0;
  bit            act     = 1'b0;
  bit            gw      = 1'b0;
  bit            gop     = 1'b0;
  bit            m_last  = 1'b1;
  logic [AW-1:0] gaddr   = '0;
  logic [DW-1:0] gwd     = '0;
  logic [DW-1:0] ref_mem [4];
  bit            ref_known [4];
  logic [DW-1:0] exp_rd  = '0;
  bit            exp_rd_known = 1'b0;
  bit            e_ack0, e_ack1, e_we, e_busy, e_issue;
  logic [DW-1:0] fill_tbl [4] = '{4'b1010, 4'b1111, 4'b0101, 4'b0011};

  // simple_mem stand-in: combinational read, write on rising edge
  logic [DW-1:0] dev_mem [4];
  assign mem_rdata = dev_mem[mem_addr];
  always @(posedge clk) if (mem_we) dev_mem[mem_addr] <= mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic model_reset();
    act = 1'b0; m_last = 1'b1;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_issue = 1'b0;
  endtask

  // Advance one clock, update the model, and return 1 time unit after the edge.
  task automatic tick();
    int d;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      act = 1'b0;
    end else if (cyc == idle_at) begin
      act = 1'b0;
      if (req0 || req1) begin
        gw     = (req0 && req1) ? !m_last : bit'(req1);
        m_last = gw;
        gop    = gw ? we1 : we0;
        gaddr  = gw ? addr1 : addr0;
        gwd    = gw ? wdata1 : wdata0;
        s      = cyc;
        lack   = gop ? 1 : 2;
        idle_at = s + lack + 2;
        act    = 1'b1;
      end else begin
        idle_at = cyc + 1;
      end
    end
    d       = cyc - s;
    e_busy  = act && d >= 0 && d <= lack;
    e_issue = act && d == 0;
    e_we    = e_issue && gop;
    e_ack0  = act && d == lack && !gw;
    e_ack1  = act && d == lack && gw;
    if (act && d == lack) begin
      if (gop) begin
        ref_mem[gaddr] = gwd; ref_known[gaddr] = 1'b1;
      end else begin
        exp_rd = ref_mem[gaddr]; exp_rd_known = ref_known[gaddr];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'b11; wdata0 = 4'b0110;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({ack0, ack1, mem_we, busy, mem_addr, mem_wdata, rdata} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs got ack0=%b ack1=%b we=%b busy=%b addr=%b wd=%b rd=%b want all 0",
                 ack0, ack1, mem_we, busy, mem_addr, mem_wdata, rdata);
      end
      tick();
    end
    rst_n = 1'b1; idle_at = cyc + 1;
    tick();
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 2'b11 || mem_wdata !== 4'b0110 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_grant got we=%b addr=%b wd=%b busy=%b want 1 11 0110 1", mem_we, mem_addr, mem_wdata, busy);
    end
    tick();
    vectors++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_ack got ack0=%b ack1=%b want 1 0", ack0, ack1);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'b00; wdata0 = 4'b1010;
    tick();
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 2'b00 || mem_wdata !== 4'b1010 || ack0 !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_issue got we=%b addr=%b wd=%b ack0=%b want 1 00 1010 0", mem_we, mem_addr, mem_wdata, ack0);
    end
    tick();
    vectors++;
    if (mem_we !== 1'b0 || ack0 !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_ack got we=%b ack0=%b want 0 1", mem_we, ack0);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_idle got ack0=%b busy=%b want 0 0", ack0, busy);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'b00;
    tick();
    tick();
    vectors++;
    if (ack1 !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_capture got ack1=%b we=%b busy=%b want 0 0 1", ack1, mem_we, busy);
    end
    tick();
    vectors++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 4'b1010) begin
      miscompares++;
      $display("FAIL rd_ack got ack1=%b ack0=%b rdata=%b want 1 0 1010", ack1, ack0, rdata);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0; model_reset();
    #1;
    tick();
    rst_n = 1'b1; idle_at = cyc + 1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'b01; wdata0 = 4'b1111;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'b01;
    tick();
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 2'b01 || mem_wdata !== 4'b1111) begin
      miscompares++;
      $display("FAIL sim_first_req0 got we=%b addr=%b wd=%b want 1 01 1111", mem_we, mem_addr, mem_wdata);
    end
    tick();
    vectors++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_ack0 got ack0=%b ack1=%b want 1 0", ack0, ack1);
    end
    req0 = 1'b0;
    tick();
    tick();
    tick();
    tick();
    vectors++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 4'b1111) begin
      miscompares++;
      $display("FAIL sim_ack1 got ack1=%b ack0=%b rdata=%b want 1 0 1111", ack1, ack0, rdata);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_fill_readback();
    int n;
    for (int i = 0; i < 8; i++) begin
      req0 = 1'b1; we0 = (i < 4); addr0 = 2'(i % 4); wdata0 = fill_tbl[i % 4];
      n = 0;
      while (n < 6) begin
        tick(); n++;
        if (ack0 === 1'b1) break;
      end
      vectors++;
      if (ack0 !== 1'b1 || n != (we0 ? 2 : 3)) begin
        miscompares++;
        $display("FAIL fill_latency op=%0d got ack0=%b after %0d cycles want 1 after %0d", i, ack0, n, we0 ? 2 : 3);
      end
      if (!we0) begin
        vectors++;
        if (rdata !== fill_tbl[i % 4]) begin
          miscompares++;
          $display("FAIL fill_rdata addr=%0d got %b want %b", i % 4, rdata, fill_tbl[i % 4]);
        end
      end
      req0 = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int n;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'b00; wdata0 = 4'b0000;
    tick();
    vectors++;
    if (mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_issue got we=%b want 1", mem_we);
    end
    rst_n = 1'b0; model_reset(); req0 = 1'b0;
    #1;
    vectors++;
    if ({mem_we, busy, ack0} !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_we_drop got we=%b busy=%b ack0=%b want 0 0 0", mem_we, busy, ack0);
    end
    tick();
    rst_n = 1'b1; idle_at = cyc + 1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'b01;
    tick();
    tick();
    rst_n = 1'b0; model_reset(); req1 = 1'b0;
    #1;
    vectors++;
    if ({ack1, mem_we, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_capture_abort got ack1=%b we=%b busy=%b want 0 0 0", ack1, mem_we, busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (ack1 !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_no_ack got ack1=%b want 0", ack1);
      end
    end
    rst_n = 1'b1; idle_at = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      req1 = (k == 0); req0 = (k == 1); we0 = 1'b0; we1 = 1'b0;
      addr1 = 2'b10; addr0 = 2'b00;
      n = 0;
      while (n < 6) begin
        tick(); n++;
        if (ack0 === 1'b1 || ack1 === 1'b1) break;
      end
      vectors++;
      if (n != 3 || {ack0, ack1} !== (k == 0 ? 2'b01 : 2'b10) || rdata !== (k == 0 ? 4'b0101 : 4'b1010)) begin
        miscompares++;
        $display("FAIL rmid_after k=%0d got n=%0d ack0=%b ack1=%b rdata=%b want n=3 rdata=%b",
                 k, n, ack0, ack1, rdata, k == 0 ? 4'b0101 : 4'b1010);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
    end
  endtask

  task automatic test_fairness();
    int acks = 0;
    int prev = -1;
    int id;
    req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = 2'($urandom_range(0, 3)); wdata0 = 4'($urandom_range(0, 15));
    req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = 2'($urandom_range(0, 3)); wdata1 = 4'($urandom_range(0, 15));
    for (int c = 0; c < 100 && acks < 8; c++) begin
      tick();
      vectors++;
      if ({ack0, ack1, mem_we, busy} !== {e_ack0, e_ack1, e_we, e_busy}) begin
        miscompares++;
        $display("FAIL fair_ctl cyc=%0d got ack0/ack1/we/busy=%b%b%b%b want %b%b%b%b",
                 cyc, ack0, ack1, mem_we, busy, e_ack0, e_ack1, e_we, e_busy);
      end
      if ((e_ack0 || e_ack1) && !gop && exp_rd_known) begin
        vectors++;
        if (rdata !== exp_rd) begin
          miscompares++;
          $display("FAIL fair_rdata cyc=%0d got %b want %b", cyc, rdata, exp_rd);
        end
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        id = (ack1 === 1'b1) ? 1 : 0;
        vectors++;
        if (id == prev) begin
          miscompares++;
          $display("FAIL fair_alternate ack#%0d got requester %0d twice in a row", acks, id);
        end
        prev = id;
        acks++;
        if (id == 0) begin
          we0 = 1'($urandom_range(0, 1)); addr0 = 2'($urandom_range(0, 3)); wdata0 = 4'($urandom_range(0, 15));
        end else begin
          we1 = 1'($urandom_range(0, 1)); addr1 = 2'($urandom_range(0, 3)); wdata1 = 4'($urandom_range(0, 15));
        end
      end
    end
    vectors++;
    if (acks != 8) begin
      miscompares++;
      $display("FAIL fair_count got %0d acks want 8", acks);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = 2'($urandom_range(0, 3)); wdata0 = 4'($urandom_range(0, 15));
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = 2'($urandom_range(0, 3)); wdata1 = 4'($urandom_range(0, 15));
      end
      tick();
      vectors++;
      if ({ack0, ack1, mem_we, busy} !== {e_ack0, e_ack1, e_we, e_busy}) begin
        miscompares++;
        $display("FAIL rand_ctl cyc=%0d got ack0/ack1/we/busy=%b%b%b%b want %b%b%b%b",
                 cyc, ack0, ack1, mem_we, busy, e_ack0, e_ack1, e_we, e_busy);
      end
      if (e_issue) begin
        vectors++;
        if (mem_addr !== gaddr || (gop && mem_wdata !== gwd)) begin
          miscompares++;
          $display("FAIL rand_issue cyc=%0d got addr=%b wd=%b want addr=%b wd=%b", cyc, mem_addr, mem_wdata, gaddr, gwd);
        end
      end
      if ((e_ack0 || e_ack1) && !gop && exp_rd_known) begin
        vectors++;
        if (rdata !== exp_rd) begin
          miscompares++;
          $display("FAIL rand_rdata cyc=%0d got %b want %b", cyc, rdata, exp_rd);
        end
      end
      if (ack0 === 1'b1) req0 = 1'b0;
      if (ack1 === 1'b1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_fill_readback();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
